// File: rtl/gpr_commit_scheduler_pkg.sv
// Shared definitions for the GPR commit scheduler: default register-file
// address/word widths and the queued commit entry layout.
package gpr_commit_scheduler_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int GPR_DATA_W = 32;

  typedef struct packed {
    logic [GPR_ADDR_W-1:0] addr;
    logic [GPR_DATA_W-1:0] data;
  } commit_entry_t;

endpackage

// File: rtl/gpr_commit_fifo.sv
// Dual-push, single-pop circular buffer holding pending GPR writes.
// Up to two entries are written per cycle (slot 0 older than slot 1), one is
// popped per cycle. Storage is exported so the top can search it for bypass.
module gpr_commit_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   push_n,
  input  logic [ADDR_W-1:0]            push0_addr,
  input  logic [DATA_W-1:0]            push0_data,
  input  logic [ADDR_W-1:0]            push1_addr,
  input  logic [DATA_W-1:0]            push1_data,
  input  logic                         pop,
  output logic [CNT_W-1:0]             count,
  output logic [PTR_W-1:0]             rd_ptr,
  output logic [DEPTH-1:0][ADDR_W-1:0] mem_addr,
  output logic [DEPTH-1:0][DATA_W-1:0] mem_data
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_next1;

  assign wr_ptr_next1 = wr_ptr + PTR_W'(1);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop);
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      mem_addr[wr_ptr] <= push0_addr;
      mem_data[wr_ptr] <= push0_data;
    end
    if (push_n == 2'd2) begin
      mem_addr[wr_ptr_next1] <= push1_addr;
      mem_data[wr_ptr_next1] <= push1_data;
    end
  end

endmodule

// File: rtl/gpr_commit_scheduler.sv
// Sequences dual-lane ROB retire results onto the single GPR write port.
// Optional feature macro: GPR_COMMIT_BYPASS_EN enables youngest-match
// forwarding of pending entries on rd_hit*/rd_data*; otherwise those are 0.
module gpr_commit_scheduler
  import gpr_commit_scheduler_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int DATA_W = GPR_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmt0_valid,
  input  logic [ADDR_W-1:0]          cmt0_addr,
  input  logic [DATA_W-1:0]          cmt0_data,
  input  logic                       cmt1_valid,
  input  logic [ADDR_W-1:0]          cmt1_addr,
  input  logic [DATA_W-1:0]          cmt1_data,
  output logic                       cmt_ready,
  output logic                       gpr_we,
  output logic [ADDR_W-1:0]          gpr_waddr,
  output logic [DATA_W-1:0]          gpr_wdata,
  input  logic [ADDR_W-1:0]          rd_addr0,
  input  logic [ADDR_W-1:0]          rd_addr1,
  output logic                       rd_hit0,
  output logic                       rd_hit1,
  output logic [DATA_W-1:0]          rd_data0,
  output logic [DATA_W-1:0]          rd_data1,
  output logic [$clog2(DEPTH):0]     pending_cnt,
  output logic                       idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]             count;
  logic [PTR_W-1:0]             rd_ptr;
  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data;
  logic                         keep0;
  logic                         keep1;
  logic [1:0]                   push_n;
  logic [ADDR_W-1:0]            push0_addr;
  logic [DATA_W-1:0]            push0_data;

  // Ready only from the registered count so a same-cycle pop never helps.
  assign cmt_ready   = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
  assign idle        = (count == '0);
  assign pending_cnt = count;

  // Writes to x0 are accepted by the handshake but dropped here.
  assign keep0  = cmt_ready && cmt0_valid && (cmt0_addr != '0);
  assign keep1  = cmt_ready && cmt1_valid && (cmt1_addr != '0);
  assign push_n = {1'b0, keep0} + {1'b0, keep1};

  // Compact lanes so a lone lane 1 lands in the first free slot.
  assign push0_addr = keep0 ? cmt0_addr : cmt1_addr;
  assign push0_data = keep0 ? cmt0_data : cmt1_data;

  // Head drains every cycle the queue is non-empty; outputs are zero when idle.
  assign gpr_we    = !idle;
  assign gpr_waddr = gpr_we ? mem_addr[rd_ptr] : '0;
  assign gpr_wdata = gpr_we ? mem_data[rd_ptr] : '0;

  gpr_commit_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_n     (push_n),
    .push0_addr (push0_addr),
    .push0_data (push0_data),
    .push1_addr (cmt1_addr),
    .push1_data (cmt1_data),
    .pop        (gpr_we),
    .count      (count),
    .rd_ptr     (rd_ptr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

`ifdef GPR_COMMIT_BYPASS_EN
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last (youngest) match wins.
  always_comb begin
    rd_hit0  = 1'b0;
    rd_hit1  = 1'b0;
    rd_data0 = '0;
    rd_data1 = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if ((rd_addr0 != '0) && (mem_addr[idx] == rd_addr0)) begin
          rd_hit0  = 1'b1;
          rd_data0 = mem_data[idx];
        end
        if ((rd_addr1 != '0) && (mem_addr[idx] == rd_addr1)) begin
          rd_hit1  = 1'b1;
          rd_data1 = mem_data[idx];
        end
      end
    end
  end
`else
  logic unused_bypass;

  assign unused_bypass = ^{rd_addr0, rd_addr1};
  assign rd_hit0  = 1'b0;
  assign rd_hit1  = 1'b0;
  assign rd_data0 = '0;
  assign rd_data1 = '0;
`endif

endmodule

// File: tb/tb_gpr_commit_scheduler.sv
// Directed self-checking bench for gpr_commit_scheduler (DEPTH=4).
// Bypass expectations follow GPR_COMMIT_BYPASS_EN as seen by this file.
module tb_gpr_commit_scheduler;
  import gpr_commit_scheduler_pkg::*;

  localparam int DEPTH = 4;

`ifdef GPR_COMMIT_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cmt0_valid, cmt1_valid;
  logic [4:0]  cmt0_addr, cmt1_addr;
  logic [31:0] cmt0_data, cmt1_data;
  logic        cmt_ready;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [4:0]  rd_addr0, rd_addr1;
  logic        rd_hit0, rd_hit1;
  logic [31:0] rd_data0, rd_data1;
  logic [2:0]  pending_cnt;
  logic        idle;

  int total = 0;
  int bad   = 0;

  gpr_commit_scheduler #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmt0_valid  (cmt0_valid),
    .cmt0_addr   (cmt0_addr),
    .cmt0_data   (cmt0_data),
    .cmt1_valid  (cmt1_valid),
    .cmt1_addr   (cmt1_addr),
    .cmt1_data   (cmt1_data),
    .cmt_ready   (cmt_ready),
    .gpr_we      (gpr_we),
    .gpr_waddr   (gpr_waddr),
    .gpr_wdata   (gpr_wdata),
    .rd_addr0    (rd_addr0),
    .rd_addr1    (rd_addr1),
    .rd_hit0     (rd_hit0),
    .rd_hit1     (rd_hit1),
    .rd_data0    (rd_data0),
    .rd_data1    (rd_data1),
    .pending_cnt (pending_cnt),
    .idle        (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_lanes(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                             input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    cmt0_valid = v0; cmt0_addr = a0; cmt0_data = d0;
    cmt1_valid = v1; cmt1_addr = a1; cmt1_data = d1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (gpr_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got=%0b exp=0", gpr_we); end
    total++; if (gpr_waddr !== 5'd0) begin bad++; $display("[TB] FAIL reset_waddr got=%0d exp=0", gpr_waddr); end
    total++; if (gpr_wdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_wdata got=%h exp=0", gpr_wdata); end
    total++; if (cmt_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%0b exp=1", cmt_ready); end
    total++; if (idle !== 1'b1) begin bad++; $display("[TB] FAIL reset_idle got=%0b exp=1", idle); end
    total++; if (pending_cnt !== 3'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d exp=0", pending_cnt); end
    total++; if (rd_hit0 !== 1'b0 || rd_data0 !== 32'd0) begin bad++; $display("[TB] FAIL reset_byp got=%0b/%h exp=0/0", rd_hit0, rd_data0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    drive_lanes(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    drive_lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rd_addr0 = 5'd5;
    #1;
    total++; if (gpr_we !== 1'b1) begin bad++; $display("[TB] FAIL single_we got=%0b exp=1", gpr_we); end
    total++; if (gpr_waddr !== 5'd5) begin bad++; $display("[TB] FAIL single_waddr got=%0d exp=5", gpr_waddr); end
    total++; if (gpr_wdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_wdata got=%h exp=deadbeef", gpr_wdata); end
    total++; if (pending_cnt !== 3'd1 || idle !== 1'b0) begin bad++; $display("[TB] FAIL single_cnt got=%0d/%0b exp=1/0", pending_cnt, idle); end
    total++; if (rd_hit0 !== BYP || rd_data0 !== (BYP ? 32'hDEADBEEF : 32'd0)) begin bad++; $display("[TB] FAIL single_byp got=%0b/%h exp=%0b", rd_hit0, rd_data0, BYP); end
    @(negedge clk);
    #1;
    total++; if (idle !== 1'b1 || gpr_we !== 1'b0) begin bad++; $display("[TB] FAIL single_drain got idle=%0b we=%0b exp=1/0", idle, gpr_we); end
    total++; if (rd_hit0 !== 1'b0) begin bad++; $display("[TB] FAIL single_byp_gone got=%0b exp=0", rd_hit0); end
    rd_addr0 = 5'd0;
  endtask

  task automatic test_dual_same();
    logic [31:0] exp_wd [2];
    exp_wd[0] = 32'd1; exp_wd[1] = 32'd2;
    @(negedge clk);
    drive_lanes(1'b1, 5'd3, 32'd1, 1'b1, 5'd3, 32'd2);
    rd_addr0 = 5'd3; rd_addr1 = 5'd3;
    @(negedge clk);
    drive_lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (gpr_we !== 1'b1 || gpr_waddr !== 5'd3 || gpr_wdata !== exp_wd[i]) begin bad++; $display("[TB] FAIL dual_write%0d got=%0b/%0d/%h exp=1/3/%h", i, gpr_we, gpr_waddr, gpr_wdata, exp_wd[i]); end
      total++; if (pending_cnt !== 3'(2 - i)) begin bad++; $display("[TB] FAIL dual_cnt%0d got=%0d exp=%0d", i, pending_cnt, 2 - i); end
      total++; if (rd_hit0 !== BYP || rd_data0 !== (BYP ? 32'd2 : 32'd0) || rd_hit1 !== BYP || rd_data1 !== (BYP ? 32'd2 : 32'd0)) begin bad++; $display("[TB] FAIL dual_byp%0d got=%0b/%h %0b/%h exp=%0b", i, rd_hit0, rd_data0, rd_hit1, rd_data1, BYP); end
      @(negedge clk);
    end
    #1;
    total++; if (idle !== 1'b1) begin bad++; $display("[TB] FAIL dual_idle got=%0b exp=1", idle); end
    rd_addr0 = 5'd0; rd_addr1 = 5'd0;
  endtask

  task automatic test_back_to_back();
    commit_entry_t q[$];
    commit_entry_t e0, e1;
    int p = 0;
    int cyc = 0;
    logic active;
    logic exp_ready;
    logic saw_not_ready = 1'b0;
    rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    while (cyc < 24 && (cyc < 10 || q.size() != 0)) begin
      @(negedge clk);
      active = (cyc < 10);
      e0.addr = 5'(8 + 2 * p); e0.data = 32'(100 + 2 * p);
      e1.addr = 5'(9 + 2 * p); e1.data = 32'(101 + 2 * p);
      drive_lanes(active, e0.addr, e0.data, active, e1.addr, e1.data);
      #1;
      exp_ready = (q.size() <= DEPTH - 2);
      if (!exp_ready) saw_not_ready = 1'b1;
      total++; if (cmt_ready !== exp_ready) begin bad++; $display("[TB] FAIL b2b_ready c%0d got=%0b exp=%0b", cyc, cmt_ready, exp_ready); end
      total++; if (pending_cnt !== 3'(q.size())) begin bad++; $display("[TB] FAIL b2b_cnt c%0d got=%0d exp=%0d", cyc, pending_cnt, q.size()); end
      if (q.size() != 0) begin
        total++; if (gpr_we !== 1'b1 || gpr_waddr !== q[0].addr || gpr_wdata !== q[0].data) begin bad++; $display("[TB] FAIL b2b_write c%0d got=%0b/%0d/%0d exp=1/%0d/%0d", cyc, gpr_we, gpr_waddr, gpr_wdata, q[0].addr, q[0].data); end
        void'(q.pop_front());
      end else begin
        total++; if (gpr_we !== 1'b0) begin bad++; $display("[TB] FAIL b2b_we_idle c%0d got=%0b exp=0", cyc, gpr_we); end
      end
      if (active && exp_ready) begin
        q.push_back(e0); q.push_back(e1); p++;
      end
      cyc++;
    end
    drive_lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    total++; if (q.size() != 0 || !saw_not_ready) begin bad++; $display("[TB] FAIL b2b_drain left=%0d backpressure_seen=%0b exp=0/1", q.size(), saw_not_ready); end
    @(negedge clk);
    #1;
    total++; if (idle !== 1'b1) begin bad++; $display("[TB] FAIL b2b_idle got=%0b exp=1", idle); end
  endtask

  task automatic test_x0_filter();
    @(negedge clk);
    drive_lanes(1'b1, 5'd0, 32'h99, 1'b1, 5'd7, 32'h55);
    rd_addr0 = 5'd0; rd_addr1 = 5'd7;
    @(negedge clk);
    drive_lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    total++; if (pending_cnt !== 3'd1) begin bad++; $display("[TB] FAIL x0_cnt got=%0d exp=1", pending_cnt); end
    total++; if (gpr_we !== 1'b1 || gpr_waddr !== 5'd7 || gpr_wdata !== 32'h55) begin bad++; $display("[TB] FAIL x0_write got=%0b/%0d/%h exp=1/7/55", gpr_we, gpr_waddr, gpr_wdata); end
    total++; if (rd_hit0 !== 1'b0 || rd_hit1 !== BYP || rd_data1 !== (BYP ? 32'h55 : 32'd0)) begin bad++; $display("[TB] FAIL x0_byp got=%0b %0b/%h exp=0 %0b", rd_hit0, rd_hit1, rd_data1, BYP); end
    @(negedge clk);
    #1;
    total++; if (gpr_we !== 1'b0 || idle !== 1'b1) begin bad++; $display("[TB] FAIL x0_after got we=%0b idle=%0b exp=0/1", gpr_we, idle); end
    rd_addr1 = 5'd0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_lanes(1'b1, 5'd1, 32'd11, 1'b1, 5'd2, 32'd22);
    @(negedge clk);
    drive_lanes(1'b1, 5'd4, 32'd44, 1'b1, 5'd6, 32'd66);
    @(negedge clk);
    drive_lanes(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    rd_addr0 = 5'd6;
    #1;
    total++; if (pending_cnt !== 3'd3 || cmt_ready !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_pre got=%0d/%0b exp=3/0", pending_cnt, cmt_ready); end
    rst_n = 1'b0;
    #1;
    total++; if (gpr_we !== 1'b0 || pending_cnt !== 3'd0 || idle !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_async got we=%0b cnt=%0d idle=%0b exp=0/0/1", gpr_we, pending_cnt, idle); end
    total++; if (rd_hit0 !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_byp got=%0b exp=0", rd_hit0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (cmt_ready !== 1'b1 || gpr_we !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_release got ready=%0b we=%0b exp=1/0", cmt_ready, gpr_we); end
    @(negedge clk);
    #1;
    total++; if (gpr_we !== 1'b0 || idle !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_stay got we=%0b idle=%0b exp=0/1", gpr_we, idle); end
    rd_addr0 = 5'd0;
  endtask

  initial begin
    $display("[TB] start, bypass=%0b", BYP);
    test_reset();
    test_single();
    test_dual_same();
    test_back_to_back();
    test_x0_filter();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
